damping_lowpass: RTL and testbench

- One-pole low-pass damping stage for one audio channel, inside the reverb core.
- Consumes 24-bit samples from the audio controller's left or right Avalon-ST source and feeds the next reverb stage via Avalon-ST.
- Coefficient comes from the 25-bit damping PIO export.
- Instantiated once per channel.

---
 rtl/reverb_pkg.sv | 32 +++
 rtl/damping_lowpass.sv | 90 +++++++++
 tb/tb_damping_lowpass.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/reverb_pkg.sv
// Shared types and helpers for the reverb core datapath stages.
// Samples are Q0.23 two's complement and coefficients are unsigned Q1.24.
package reverb_pkg;

    localparam int SAMPLE_W  = 24;
    localparam int COEF_W    = 25;
    localparam int COEF_FRAC = 24;
    localparam logic [COEF_W-1:0] COEF_ONE = 25'h1000000;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [COEF_W-1:0]          coef_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        OUT
    } lp_state_t;

    localparam logic signed [SAMPLE_W+1:0] SAT_MAX = 26'sd8388607;
    localparam logic signed [SAMPLE_W+1:0] SAT_MIN = -26'sd8388608;

    // Clamp a two-guard-bit sum back into the sample range.
    function automatic sample_t sat_sample(input logic signed [SAMPLE_W+1:0] s);
        if (s > SAT_MAX) begin
            return sample_t'(SAT_MAX[SAMPLE_W-1:0]);
        end else if (s < SAT_MIN) begin
            return sample_t'(SAT_MIN[SAMPLE_W-1:0]);
        end
        return sample_t'(s[SAMPLE_W-1:0]);
    endfunction

endpackage

// File: rtl/damping_lowpass.sv
// One-pole damping low-pass, y[n] = x[n] + d*(y[n-1] - x[n]), with Avalon-ST in/out.
// A sample is accepted in IDLE, multiplied in MUL, then rounded, saturated and held in OUT.
module damping_lowpass #(
    parameter int DATA_W    = reverb_pkg::SAMPLE_W,
    parameter int COEF_W    = reverb_pkg::COEF_W,
    parameter int COEF_FRAC = reverb_pkg::COEF_FRAC
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [COEF_W-1:0] damping_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    import reverb_pkg::*;

    localparam logic [COEF_W-1:0] D_ONE = COEF_W'(1) << COEF_FRAC;
    localparam int PROD_W = DATA_W + COEF_W + 1;

    lp_state_t                state;
    logic signed [DATA_W-1:0] x_p0;
    logic [COEF_W-1:0]        d_p0;
    logic signed [PROD_W-1:0] prod_p1;
    logic signed [DATA_W-1:0] y_prev;

    logic signed [DATA_W:0]   diff;
    logic signed [PROD_W:0]   prod_full;
    logic signed [DATA_W+1:0] sum;

    // Round half up: add 2^(FRAC-1) then arithmetic shift by FRAC.
    function automatic logic signed [DATA_W+1:0] round_q(input logic signed [PROD_W-1:0] p);
        logic signed [PROD_W-1:0] biased;
        biased = p + (PROD_W'(1) << (COEF_FRAC - 1));
        return biased[PROD_W-1:COEF_FRAC];
    endfunction

    assign diff      = (DATA_W+1)'(y_prev) - (DATA_W+1)'(x_p0);
    assign prod_full = (PROD_W+1)'(diff) * (PROD_W+1)'($signed({1'b0, d_p0}));
    assign sum       = (DATA_W+2)'(x_p0) + round_q(prod_p1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            y_prev    <= '0;
        end else begin
            case (state)
                // stage p0: capture sample and clamped coefficient
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_ready && in_valid) begin
                        x_p0     <= in_data;
                        d_p0     <= (damping_i > D_ONE) ? D_ONE : damping_i;
                        in_ready <= 1'b0;
                        state    <= MUL;
                    end
                end
                // stage p1: full-precision product of history error and coefficient
                MUL: begin
                    prod_p1 <= prod_full[PROD_W-1:0];
                    state   <= OUT;
                end
                // stage p2: first OUT cycle registers the result, then hold until taken
                OUT: begin
                    if (!out_valid) begin
                        out_data  <= sat_sample(sum);
                        y_prev    <= sat_sample(sum);
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Flush overrides any history update made on this edge.
            if (flush_i) begin
                y_prev <= '0;
            end
        end
    end

endmodule

// File: tb/tb_damping_lowpass.sv
// Directed and randomized check of damping_lowpass against an integer-arithmetic filter model.
module tb_damping_lowpass;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [24:0] damping_i = '0;
    logic        flush_i = 1'b0;
    logic [23:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int     n_checks = 0;
    int     n_fails  = 0;
    longint y_model  = 0;

    damping_lowpass dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .damping_i (damping_i),
        .flush_i   (flush_i),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        flush_i  = 1'b0;
        reset_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        y_model = 0;
    endtask

    // Push one sample; the model output is y = x + round_half_up(d*(y_prev - x)/2^24), saturated.
    task automatic send(input logic [23:0] x, input logic [24:0] d, input int hold,
                        input bit flush_acc, input bit flush_hold, input string tag,
                        output logic [23:0] obs);
        int          n;
        longint      xi, dd, p, s;
        logic [23:0] exp_y;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
        if (flush_acc) y_model = 0;
        xi = longint'($signed(x));
        dd = (d > 25'h1000000) ? 64'sh1000000 : longint'(d);
        p  = (y_model - xi) * dd;
        s  = xi + ((p + 64'sd8388608) >>> 24);
        if (s > 8388607) s = 8388607;
        else if (s < -8388608) s = -8388608;
        y_model = s;
        exp_y   = s[23:0];

        in_data   = x;
        damping_i = d;
        in_valid  = 1'b1;
        flush_i   = flush_acc;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush_i  = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, ".lat"}, 32'(n), 32'd2);
        chk({tag, ".data"}, 32'(out_data), 32'(exp_y));
        obs = out_data;
        for (int i = 0; i < hold; i++) begin
            if (flush_hold && i == 2) flush_i = 1'b1;
            @(posedge clk);
            #1;
            flush_i = 1'b0;
            chk({tag, ".hold_vld"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_data"}, 32'(out_data), 32'(exp_y));
            chk({tag, ".hold_rdy"}, 32'(in_ready), 32'd0);
        end
        if (flush_hold) y_model = 0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".done"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [23:0] y;
        logic [23:0] rx;
        logic [24:0] rd;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_data", 32'(out_data), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.in_ready_after", 32'(in_ready), 32'd1);

        // Passthrough with d = 0
        send(24'h123456, 25'h0, 0, 0, 0, "pass0", y);
        chk("pass0.lit", 32'(y), 32'h123456);
        send(24'hF00000, 25'h0, 0, 0, 0, "pass1", y);
        chk("pass1.lit", 32'(y), 32'hF00000);

        // d = 0.5 step response
        do_reset();
        send(24'h100000, 25'h0800000, 0, 0, 0, "half0", y);
        chk("half0.lit", 32'(y), 32'h080000);
        send(24'h100000, 25'h0800000, 0, 0, 0, "half1", y);
        chk("half1.lit", 32'(y), 32'h0C0000);
        send(24'h100000, 25'h0800000, 0, 0, 0, "half2", y);
        chk("half2.lit", 32'(y), 32'h0E0000);

        // Coefficient clamp to 1.0, then full-scale negative passthrough
        do_reset();
        send(24'h7FFFFF, 25'h1FFFFFF, 0, 0, 0, "clamp", y);
        chk("clamp.lit", 32'(y), 32'h000000);
        send(24'h800000, 25'h0, 0, 0, 0, "negfs", y);
        chk("negfs.lit", 32'(y), 32'h800000);

        // Backpressure for 5 cycles, with a flush landing while the output is held
        do_reset();
        send(24'h100000, 25'h0800000, 5, 0, 1, "bp", y);
        chk("bp.lit", 32'(y), 32'h080000);
        send(24'h100000, 25'h0800000, 0, 0, 0, "bp_after", y);
        chk("bp_after.lit", 32'(y), 32'h080000);

        // Flush pulse in IDLE
        do_reset();
        send(24'h100000, 25'h0800000, 0, 0, 0, "fl0", y);
        send(24'h100000, 25'h0800000, 0, 0, 0, "fl1", y);
        chk("fl1.lit", 32'(y), 32'h0C0000);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        y_model = 0;
        send(24'h100000, 25'h0800000, 0, 0, 0, "fl2", y);
        chk("fl2.lit", 32'(y), 32'h080000);

        // Flush coincident with acceptance filters against zero
        send(24'h100000, 25'h0800000, 0, 0, 0, "flacc0", y);
        send(24'h100000, 25'h0800000, 0, 1, 0, "flacc1", y);
        chk("flacc1.lit", 32'(y), 32'h080000);

        // Reset while the sample is in MUL
        in_data   = 24'h345678;
        damping_i = 25'h0800000;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset_n  = 1'b0;
        @(posedge clk);
        #1;
        chk("rstmul.out_valid", 32'(out_valid), 32'd0);
        chk("rstmul.out_data", 32'(out_data), 32'd0);
        chk("rstmul.in_ready", 32'(in_ready), 32'd0);
        reset_n = 1'b1;
        y_model = 0;
        @(posedge clk);
        #1;
        chk("rstmul.in_ready_after", 32'(in_ready), 32'd1);
        send(24'h100000, 25'h0800000, 0, 0, 0, "rstmul", y);
        chk("rstmul.lit", 32'(y), 32'h080000);

        // Randomized samples, coefficients and backpressure
        for (int k = 0; k < 30; k++) begin
            rx = 24'($urandom());
            case ($urandom_range(0, 3))
                0:       rd = 25'h0;
                1:       rd = 25'h1000000;
                2:       rd = 25'($urandom_range(25'h1000001, 25'h1FFFFFF));
                default: rd = 25'($urandom_range(0, 25'hFFFFFF));
            endcase
            send(rx, rd, int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), 1'b0, "rnd", y);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
